// File: rtl/cv_norm_pipe.sv
// Two-stage elastic normalisation pipeline: stage 1 captures the raw item and its leading-zero
// count, stage 2 left-justifies the mantissa and adjusts the exponent with a subnormal clamp.
module cv_norm_pipe #(
    parameter int MANT_WIDTH = 26,
    parameter int EXP_WIDTH  = 10,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [MANT_WIDTH-1:0] in_mant_i,
    input  logic [EXP_WIDTH-1:0]  in_exp_i,
    input  logic [TAG_WIDTH-1:0]  in_tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [MANT_WIDTH-1:0] out_mant_o,
    output logic [EXP_WIDTH-1:0]  out_exp_o,
    output logic                  out_zero_o,
    output logic                  out_denorm_o,
    output logic [TAG_WIDTH-1:0]  out_tag_o
);
    localparam int CW = (MANT_WIDTH > 1) ? $clog2(MANT_WIDTH) : 1;

    // Leading-zero count from the MSB; the value for an all-zero input is irrelevant (empty flag).
    function automatic logic [CW-1:0] f_lzc(input logic [MANT_WIDTH-1:0] m);
        logic [CW-1:0] c;
        logic          found;
        c     = '0;
        found = 1'b0;
        for (int i = MANT_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      c = c + CW'(1);
            end
        end
        return c;
    endfunction

    logic                  r1_vld, r2_vld;
    logic [MANT_WIDTH-1:0] r1_mant, r2_mant;
    logic [EXP_WIDTH-1:0]  r1_exp, r2_exp;
    logic [TAG_WIDTH-1:0]  r1_tag, r2_tag;
    logic [CW-1:0]         r1_cnt;
    logic                  r1_empty;
    logic                  r2_zero, r2_denorm;

    logic                  w_s2_load, w_s1_load, w_accept;
    logic [EXP_WIDTH:0]    w_d;
    logic                  w_exp_lt1, w_d_ge1;
    logic [CW-1:0]         w_sh;
    logic [MANT_WIDTH-1:0] w_mant;
    logic [EXP_WIDTH-1:0]  w_exp;
    logic                  w_zero, w_denorm;

    assign w_s2_load  = !r2_vld || out_ready_i;
    assign w_s1_load  = !r1_vld || w_s2_load;
    assign in_ready_o = !flush_i && w_s1_load;
    assign w_accept   = in_valid_i && in_ready_o;

    // d is one bit wider than the exponent so exp - cnt cannot wrap.
    assign w_d       = {r1_exp[EXP_WIDTH-1], r1_exp} - {{(EXP_WIDTH + 1 - CW){1'b0}}, r1_cnt};
    assign w_exp_lt1 = r1_exp[EXP_WIDTH-1] || (r1_exp == '0);
    assign w_d_ge1   = !w_d[EXP_WIDTH] && (w_d != '0);

    always_comb begin
        w_sh     = '0;
        w_exp    = r1_exp;
        w_zero   = 1'b0;
        w_denorm = 1'b0;
        if (r1_empty) begin
            w_exp  = '0;
            w_zero = 1'b1;
        end else if (w_exp_lt1) begin
            w_denorm = 1'b1;
        end else if (w_d_ge1) begin
            w_sh  = r1_cnt;
            w_exp = w_d[EXP_WIDTH-1:0];
        end else begin
            // exp-1 < cnt here, so it fits the count width
            w_sh     = r1_exp[CW-1:0] - CW'(1);
            w_exp    = '0;
            w_denorm = 1'b1;
        end
        w_mant = r1_empty ? '0 : (r1_mant << w_sh);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_vld    <= 1'b0;
            r2_vld    <= 1'b0;
            r1_mant   <= '0;
            r1_exp    <= '0;
            r1_tag    <= '0;
            r1_cnt    <= '0;
            r1_empty  <= 1'b0;
            r2_mant   <= '0;
            r2_exp    <= '0;
            r2_tag    <= '0;
            r2_zero   <= 1'b0;
            r2_denorm <= 1'b0;
        end else begin
            if (flush_i) begin
                r1_vld <= 1'b0;
                r2_vld <= 1'b0;
            end else begin
                if (w_s2_load) r2_vld <= r1_vld;
                if (w_s1_load) r1_vld <= w_accept;
            end
            if (w_accept) begin
                r1_mant  <= in_mant_i;
                r1_exp   <= in_exp_i;
                r1_tag   <= in_tag_i;
                r1_cnt   <= f_lzc(in_mant_i);
                r1_empty <= (in_mant_i == '0);
            end
            if (w_s2_load && r1_vld) begin
                r2_mant   <= w_mant;
                r2_exp    <= w_exp;
                r2_tag    <= r1_tag;
                r2_zero   <= w_zero;
                r2_denorm <= w_denorm;
            end
        end
    end

    assign out_valid_o  = r2_vld;
    assign out_mant_o   = r2_mant;
    assign out_exp_o    = r2_exp;
    assign out_zero_o   = r2_zero;
    assign out_denorm_o = r2_denorm;
    assign out_tag_o    = r2_tag;
endmodule

// File: tb/tb_cv_norm_pipe.sv
// Bench for cv_norm_pipe (8-bit mantissa/exponent): directed table, backpressure, flush,
// reset and random streaming, all checked through an expected-result queue.
module tb_cv_norm_pipe;
    typedef struct packed {
        logic [7:0] mant;
        logic [7:0] exp;
        logic       zero;
        logic       denorm;
        logic [3:0] tag;
    } out_t;

    typedef struct {
        logic [7:0] mant;
        logic [7:0] exp;
        out_t       ex;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1, flush_i = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_zero, out_denorm;
    logic [7:0] in_mant = '0, in_exp = '0, out_mant, out_exp;
    logic [3:0] in_tag = '0, out_tag;

    int   n_chk = 0, n_pass = 0, n_acc = 0;
    out_t q[$];
    out_t cur_exp;
    logic last_acc = 1'b0, prev_hold = 1'b0, prev_rst = 1'b0, prev_flush = 1'b0;
    out_t prev_outs;
    vec_t tbl[12];

    cv_norm_pipe #(.MANT_WIDTH(8), .EXP_WIDTH(8), .TAG_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_mant_i(in_mant), .in_exp_i(in_exp), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_mant_o(out_mant), .out_exp_o(out_exp), .out_zero_o(out_zero),
        .out_denorm_o(out_denorm), .out_tag_o(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference: shift one bit at a time while the exponent stays above the minimum normal.
    function automatic out_t ref_norm(input logic [7:0] m, input logic [7:0] e, input logic [3:0] t);
        out_t       r;
        int         ee;
        logic [7:0] mm;
        r = '0;
        r.tag = t;
        ee = int'($signed(e));
        mm = m;
        if (m == 8'd0) begin
            r.zero = 1'b1;
        end else if (ee < 1) begin
            r.mant = m;
            r.exp = e;
            r.denorm = 1'b1;
        end else begin
            while (!mm[7] && ee > 1) begin
                mm = mm << 1;
                ee--;
            end
            r.mant = mm;
            if (mm[7]) r.exp = 8'(ee);
            else r.denorm = 1'b1;
        end
        return r;
    endfunction

    function automatic out_t cur_outs();
        out_t o;
        o = '{out_mant, out_exp, out_zero, out_denorm, out_tag};
        return o;
    endfunction

    // Scoreboard/monitor: inputs only change just after posedge, so handshakes are decided here.
    always @(negedge clk) begin
        if (prev_rst || prev_flush) chk("valid_cleared", 64'(out_valid), 64'd0);
        if (rst_i) begin
            q.delete();
            last_acc = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", 64'(cur_outs()), 64'(prev_outs));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got %0h, expected no output", cur_outs());
                end else begin
                    chk("out_item", 64'(cur_outs()), 64'(q.pop_front()));
                end
            end
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                q.push_back(cur_exp);
                n_acc++;
            end
            if (flush_i) q.delete();
            prev_hold = out_valid && !out_ready && !flush_i;
            prev_outs = cur_outs();
        end
        prev_rst = rst_i;
        prev_flush = flush_i;
    end

    task automatic send(input logic [7:0] m, input logic [7:0] e, input logic [3:0] t, input out_t ex);
        bit ok;
        ok = 1'b0;
        in_mant = m; in_exp = e; in_tag = t; cur_exp = ex; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout: got in_ready 0, expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        out_t ex;
        tbl[0]  = '{8'h16, 8'd10,  '{8'hB0, 8'd7,  1'b0, 1'b0, 4'd0}};
        tbl[1]  = '{8'h80, 8'd5,   '{8'h80, 8'd5,  1'b0, 1'b0, 4'd0}};
        tbl[2]  = '{8'h04, 8'd3,   '{8'h10, 8'd0,  1'b0, 1'b1, 4'd0}};
        tbl[3]  = '{8'h03, 8'hFE,  '{8'h03, 8'hFE, 1'b0, 1'b1, 4'd0}};
        tbl[4]  = '{8'h00, 8'd20,  '{8'h00, 8'd0,  1'b1, 1'b0, 4'd0}};
        tbl[5]  = '{8'h01, 8'd8,   '{8'h80, 8'd1,  1'b0, 1'b0, 4'd0}};
        tbl[6]  = '{8'h01, 8'd1,   '{8'h01, 8'd0,  1'b0, 1'b1, 4'd0}};
        tbl[7]  = '{8'h40, 8'd127, '{8'h80, 8'd126,1'b0, 1'b0, 4'd0}};
        tbl[8]  = '{8'hFF, 8'h80,  '{8'hFF, 8'h80, 1'b0, 1'b1, 4'd0}};
        tbl[9]  = '{8'h00, 8'hFB,  '{8'h00, 8'd0,  1'b1, 1'b0, 4'd0}};
        tbl[10] = '{8'h02, 8'd0,   '{8'h02, 8'd0,  1'b0, 1'b1, 4'd0}};
        tbl[11] = '{8'h01, 8'd7,   '{8'h40, 8'd0,  1'b0, 1'b1, 4'd0}};

        // Reset state
        idle(3);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outs", 64'(cur_outs()), 64'd0);
        @(posedge clk); #1;

        // Directed vectors, back-to-back at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ex = tbl[i].ex;
            ex.tag = 4'(i);
            send(tbl[i].mant, tbl[i].exp, 4'(i), ex);
        end
        idle(4);
        chk("tbl_drained", 64'(q.size()), 64'd0);

        // Backpressure: two accepts fill the pipe, third waits
        out_ready = 1'b0;
        send(8'h16, 8'd10, 4'd1, ref_norm(8'h16, 8'd10, 4'd1));
        send(8'h05, 8'd2,  4'd2, ref_norm(8'h05, 8'd2,  4'd2));
        in_mant = 8'h30; in_exp = 8'd9; in_tag = 4'd3; in_valid = 1'b1;
        cur_exp = ref_norm(8'h30, 8'd9, 4'd3);
        @(negedge clk);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_tag", 64'(out_tag), 64'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h30, 8'd9, 4'd3, ref_norm(8'h30, 8'd9, 4'd3));
        idle(4);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Flush with both stages full, then latency of the next item
        out_ready = 1'b0;
        send(8'h11, 8'd6, 4'd4, ref_norm(8'h11, 8'd6, 4'd4));
        send(8'h22, 8'd6, 4'd5, ref_norm(8'h22, 8'd6, 4'd5));
        flush_i = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        chk("post_flush_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h09, 8'd12, 4'd6, ref_norm(8'h09, 8'd12, 4'd6));
        @(negedge clk);
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        chk("lat_tag", 64'(out_tag), 64'd6);
        idle(3);

        // Random streaming with random ready/valid, occasional flush, one mid-stream reset
        n_acc = 0;
        for (int cyc = 0; cyc < 30000 && n_acc < 3000; cyc++) begin
            @(posedge clk); #1;
            rst_i = (cyc == 900);
            flush_i = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: in_mant = 8'd0;
                    1: in_mant = 8'($urandom_range(1, 15));
                    default: in_mant = 8'($urandom) >> $urandom_range(0, 7);
                endcase
                in_exp = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) - 8'd3 : 8'($urandom);
                in_tag = 4'($urandom);
                cur_exp = ref_norm(in_mant, in_exp, in_tag);
            end
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        flush_i = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("rand_drained", 64'(q.size()), 64'd0);
        chk("rand_progress", 64'(n_acc >= 1000), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
